// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone transmit-only UART.
// Bus widths, register offsets, STATUS bit indices and TX FSM states.
package wb_uart_pkg;

    localparam int WB_COM_AWIDTH = 32;
    localparam int WB_COM_DWIDTH = 32;

    // Byte offsets; only bits [3:2] are decoded.
    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;
    localparam logic [3:0] UART_IE     = 4'hC;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_LVL_LO = 8;
    localparam int ST_LVL_HI = 15;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone B4 pipelined single-beat bus bundle for wb_uart_tx.
// Ports: adr/dat/sel/we/cyc/stb from master; dat_o/ack/err from slave.
interface wb_uart_if;
    import wb_uart_pkg::*;

    logic [WB_COM_AWIDTH-1:0]   wb_adr_i;
    logic [WB_COM_DWIDTH-1:0]   wb_dat_i;
    logic [WB_COM_DWIDTH/8-1:0] wb_sel_i;
    logic                       wb_we_i;
    logic                       wb_cyc_i;
    logic                       wb_stb_i;
    logic [WB_COM_DWIDTH-1:0]   wb_dat_o;
    logic                       wb_ack_o;
    logic                       wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra pointer wrap bit.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, level.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign level = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave transmit-only 8N1 UART with TX FIFO and baud divisor.
// Ports: clk, rst_n, wb (slave bundle), txd_o, irq_o (WB_UART_IRQ_EN).
module wb_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_uart_if.slave wb,
    output logic     txd_o
`ifdef WB_UART_IRQ_EN
    ,
    output logic     irq_o
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                     req;
    logic                     wr;
    logic                     is_tx;
    logic                     is_st;
    logic                     is_div;
    logic                     is_hi;
    logic                     mapped;
    logic                     push;
    logic                     push_rej;
    logic                     ovf_clr;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     busy;
    logic [LW-1:0]            level;
    logic [7:0]               fifo_dout;
    logic [31:0]              status;
    logic [WB_COM_DWIDTH-1:0] rd_data;

    logic                     ack_q;
    logic                     err_q;
    logic [WB_COM_DWIDTH-1:0] dat_q;
    logic                     ovf_q;
    logic [15:0]              div_q;

    uart_tx_state_t           state_q;
    uart_tx_state_t           state_d;
    logic [15:0]              cnt_q;
    logic [15:0]              cnt_d;
    logic [2:0]               bit_q;
    logic [2:0]               bit_d;
    logic [7:0]               sh_q;
    logic [7:0]               sh_d;
    logic                     txd_q;
    logic                     txd_d;
    logic                     tick;

    logic                     unused_bits;

    assign unused_bits = ^{wb.wb_adr_i[WB_COM_AWIDTH-1:4],
                           wb.wb_adr_i[1:0],
                           wb.wb_dat_i[WB_COM_DWIDTH-1:16],
                           wb.wb_sel_i[WB_COM_DWIDTH/8-1:2]};

    assign req = wb.wb_cyc_i & wb.wb_stb_i;
    assign wr  = req & wb.wb_we_i;

    always_comb begin
        is_tx  = (wb.wb_adr_i[3:2] == UART_TXDATA[3:2]);
        is_st  = (wb.wb_adr_i[3:2] == UART_STATUS[3:2]);
        is_div = (wb.wb_adr_i[3:2] == UART_DIV[3:2]);
        is_hi  = (wb.wb_adr_i[3:2] == UART_IE[3:2]);
    end

`ifdef WB_UART_IRQ_EN
    assign mapped = 1'b1;
`else
    assign mapped = ~is_hi;
`endif

    // FULL is the registered flag, so a pop in the same cycle
    // does not make room for this push.
    assign push     = wr & is_tx & wb.wb_sel_i[0] & ~full;
    assign push_rej = wr & is_tx & wb.wb_sel_i[0] & full;
    assign ovf_clr  = wr & is_st & wb.wb_sel_i[0] &
                      wb.wb_dat_i[ST_OVF];
    assign busy     = (state_q != IDLE);

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wb.wb_dat_i[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        status                      = '0;
        status[ST_FULL]             = full;
        status[ST_EMPTY]            = empty;
        status[ST_BUSY]             = busy;
        status[ST_OVF]              = ovf_q;
        status[ST_LVL_HI:ST_LVL_LO] = 8'(level);
    end

`ifdef WB_UART_IRQ_EN
    logic ie_q;
    logic irq_q;
`endif

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            is_tx:  rd_data = '0;
            is_st:  rd_data = status;
            is_div: rd_data = {16'h0, div_q};
`ifdef WB_UART_IRQ_EN
            is_hi:  rd_data = {31'h0, ie_q};
`else
            is_hi:  rd_data = '0;
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
            div_q <= DIV_RESET;
        end else begin
            ack_q <= req & mapped;
            err_q <= req & ~mapped;
            dat_q <= (req & mapped & ~wb.wb_we_i) ? rd_data : '0;
            if (push_rej) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (wr & is_div) begin
                if (wb.wb_sel_i[0]) div_q[7:0]  <= wb.wb_dat_i[7:0];
                if (wb.wb_sel_i[1]) div_q[15:8] <= wb.wb_dat_i[15:8];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;

`ifdef WB_UART_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr & is_hi & wb.wb_sel_i[0]) begin
                ie_q <= wb.wb_dat_i[0];
            end
            irq_q <= ie_q & empty & ~busy;
        end
    end

    assign irq_o = irq_q;
`endif

    // cnt counts down the current bit; the divisor is sampled only
    // at bit boundaries so a bit in flight keeps its period.
    assign tick = (cnt_q == 16'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_dout;
                    state_d = START;
                    txd_d   = 1'b0;
                    cnt_d   = div_q;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = 3'd0;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_dout;
                        state_d = START;
                        txd_d   = 1'b0;
                        cnt_d   = div_q;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

    assign txd_o = txd_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx with a frame-level reference model.
// Drives the Wishbone bundle; watches txd_o every cycle.
module tb_wb_uart_tx;
    import wb_uart_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [15:0] DIVR  = 16'd433;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic txd;
`ifdef WB_UART_IRQ_EN
    logic irq;
`endif

    wb_uart_if bus ();

    wb_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (DIVR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave),
        .txd_o (txd)
`ifdef WB_UART_IRQ_EN
        ,
        .irq_o (irq)
`endif
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_cnt = 0;
    logic wave [4096];
    logic [15:0] cur_div;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) wave[cyc_cnt % 4096] = txd;

    logic        op_we  [32];
    logic [31:0] op_adr [32];
    logic [31:0] op_dat [32];
    logic [3:0]  op_sel [32];
    logic [31:0] r_dat  [32];
    logic        r_ack  [32];
    logic        r_err  [32];
    int          seq_start;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic wv(input int c);
        return wave[c % 4096];
    endfunction

    // Issues n pipelined single-beat accesses, one per cycle.
    task automatic run_ops(input int n);
        @(negedge clk);
        seq_start = cyc_cnt;
        for (int i = 0; i < n; i++) begin
            bus.wb_cyc_i = 1'b1;
            bus.wb_stb_i = 1'b1;
            bus.wb_we_i  = op_we[i];
            bus.wb_adr_i = op_adr[i];
            bus.wb_dat_i = op_dat[i];
            bus.wb_sel_i = op_sel[i];
            @(negedge clk);
            r_dat[i] = bus.wb_dat_o;
            r_ack[i] = bus.wb_ack_o;
            r_err[i] = bus.wb_err_o;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wb_op(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rd, output logic ack,
                         output logic err);
        op_we[0] = we; op_adr[0] = adr;
        op_dat[0] = dat; op_sel[0] = sel;
        run_ops(1);
        rd = r_dat[0]; ack = r_ack[0]; err = r_err[0];
    endtask

    task automatic set_div(input logic [15:0] d);
        logic [31:0] rd;
        logic a, e;
        wb_op(1'b1, 32'h8, {16'h0, d}, 4'b0011, rd, a, e);
        cur_div = d;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic a, e;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.wb_ack_o !== 1'b0) $display("FAIL rst_ack got %b want 0", bus.wb_ack_o);
        else n_pass++;
        n_chk++;
        if (bus.wb_err_o !== 1'b0) $display("FAIL rst_err got %b want 0", bus.wb_err_o);
        else n_pass++;
        n_chk++;
        if (bus.wb_dat_o !== 32'h0) $display("FAIL rst_dat got %h want 0", bus.wb_dat_o);
        else n_pass++;
        n_chk++;
        if (txd !== 1'b1) $display("FAIL rst_txd got %b want 1", txd);
        else n_pass++;
        rst_n = 1'b1;
        cur_div = DIVR;
        wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if ({a, e, rd} !== {1'b1, 1'b0, 32'h2})
            $display("FAIL rst_status got ack=%b err=%b dat=%h want 1 0 00000002", a, e, rd);
        else n_pass++;
        wb_op(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== {16'h0, DIVR}) $display("FAIL rst_div got %h want %h", rd, DIVR);
        else n_pass++;
    endtask

    task automatic test_divisor;
        logic [31:0] rd, dat;
        logic [3:0] sel;
        logic a, e;
        for (int i = 0; i < 5; i++) begin
            dat = $urandom;
            sel = (i == 0) ? 4'hF : 4'($urandom_range(0, 15));
            wb_op(1'b1, 32'h8, dat, sel, rd, a, e);
            if (sel[0]) cur_div[7:0]  = dat[7:0];
            if (sel[1]) cur_div[15:8] = dat[15:8];
            wb_op(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e);
            n_chk++;
            if (rd !== {16'h0, cur_div})
                $display("FAIL div_lane[%0d] sel=%h got %h want %h", i, sel, rd, cur_div);
            else n_pass++;
        end
    endtask

    task automatic test_frame;
        logic [7:0] b;
        logic [15:0] d;
        int f, s, bad;
        logic [31:0] rd;
        logic a, e;
        // A TXDATA write without lane 0 must not enqueue.
        op_we[0] = 1'b1; op_adr[0] = 32'h0;
        op_dat[0] = 32'hA5; op_sel[0] = 4'b1110;
        op_we[1] = 1'b0; op_adr[1] = 32'h4;
        op_dat[1] = 32'h0; op_sel[1] = 4'hF;
        run_ops(2);
        n_chk++;
        if (r_dat[1] !== 32'h2) $display("FAIL sel0_off got %h want 00000002", r_dat[1]);
        else n_pass++;
        for (int it = 0; it < 4; it++) begin
            b = (it == 0) ? 8'h55 : 8'($urandom);
            d = (it == 0) ? 16'd3 : 16'($urandom_range(0, 4));
            set_div(d);
            f = 10 * (int'(d) + 1);
            op_we[0] = 1'b1; op_adr[0] = 32'h0;
            op_dat[0] = {$urandom, b} ; op_sel[0] = 4'b0001;
            op_we[1] = 1'b0; op_adr[1] = 32'h4;
            op_dat[1] = 32'h0; op_sel[1] = 4'hF;
            run_ops(2);
            s = seq_start;
            n_chk++;
            if ({r_ack[0], r_err[0]} !== 2'b10)
                $display("FAIL tx_ack[%0d] got ack=%b err=%b want 1 0", it, r_ack[0], r_err[0]);
            else n_pass++;
            n_chk++;
            if (r_dat[1] !== 32'h100)
                $display("FAIL tx_level[%0d] got %h want 00000100", it, r_dat[1]);
            else n_pass++;
            repeat (f + 4) @(negedge clk);
            bad = 0;
            if (wv(s + 1) !== 1'b1) bad++;
            for (int i = 0; i < f; i++)
                if (wv(s + 2 + i) !== frame_bit(b, i / (int'(d) + 1))) bad++;
            if (wv(s + 2 + f) !== 1'b1) bad++;
            n_chk++;
            if (bad != 0)
                $display("FAIL frame[%0d] byte=%h div=%0d got %0d bad cycles want 0", it, b, d, bad);
            else n_pass++;
            wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
            n_chk++;
            if (rd !== 32'h2) $display("FAIL idle_after[%0d] got %h want 00000002", it, rd);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int n, f, s, occ, bl, bad, k;
        logic ovf;
        logic [31:0] exp_st, rd;
        logic [7:0] bytes [16];
        logic [7:0] acc [$];
        logic a, e;
        set_div(16'd0);
        f = 10;
        n = 9 + $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            bytes[i] = 8'($urandom);
            op_we[i] = 1'b1; op_adr[i] = 32'h0;
            op_dat[i] = {24'h0, bytes[i]}; op_sel[i] = 4'h1;
        end
        op_we[n] = 1'b0; op_adr[n] = 32'h4;
        op_dat[n] = 32'h0; op_sel[n] = 4'hF;
        run_ops(n + 1);
        s = seq_start;
        // Occupancy / frame-time model: bl is frame cycles left.
        occ = 0; bl = 0; ovf = 1'b0; exp_st = '0;
        for (int c = 0; c <= n; c++) begin
            logic p, q;
            if (c == n)
                exp_st = {16'h0, 8'(occ), 4'h0, ovf, (bl > 0),
                          (occ == 0), (occ == DEPTH)};
            p = 1'b0;
            if (c < n) begin
                if (occ < DEPTH) begin
                    p = 1'b1;
                    acc.push_back(bytes[c]);
                end else ovf = 1'b1;
            end
            q = (occ > 0) && (bl <= 1);
            occ = occ + int'(p) - int'(q);
            bl = q ? f : (bl > 0 ? bl - 1 : 0);
        end
        n_chk++;
        if (r_dat[n] !== exp_st)
            $display("FAIL b2b_status n=%0d got %h want %h", n, r_dat[n], exp_st);
        else n_pass++;
        repeat (acc.size() * f + 12) @(negedge clk);
        k = 0;
        foreach (acc[j]) begin
            bad = 0;
            for (int i = 0; i < f; i++)
                if (wv(s + 2 + j * f + i) !== frame_bit(acc[j], i)) bad++;
            n_chk++;
            if (bad != 0)
                $display("FAIL b2b_frame[%0d] byte=%h got %0d bad cycles want 0", j, acc[j], bad);
            else n_pass++;
            k++;
        end
        n_chk++;
        if (wv(s + 2 + k * f) !== 1'b1)
            $display("FAIL b2b_tail got %b want 1", wv(s + 2 + k * f));
        else n_pass++;
        wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== {28'h0, ovf, 3'b010})
            $display("FAIL b2b_drained got %h want %h", rd, {28'h0, ovf, 3'b010});
        else n_pass++;
        wb_op(1'b1, 32'h4, 32'h8, 4'h1, rd, a, e);
    endtask

    task automatic test_unmapped;
        logic [31:0] rd;
        logic a, e;
`ifdef WB_UART_IRQ_EN
        wb_op(1'b1, 32'hC, 32'h1, 4'h1, rd, a, e);
        n_chk++;
        if ({a, e} !== 2'b10) $display("FAIL ie_wr got ack=%b err=%b want 1 0", a, e);
        else n_pass++;
        wb_op(1'b0, 32'hC, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== 32'h1) $display("FAIL ie_rd got %h want 1", rd);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (irq !== 1'b1) $display("FAIL irq_drained got %b want 1", irq);
        else n_pass++;
        wb_op(1'b1, 32'hC, 32'h0, 4'h1, rd, a, e);
        repeat (3) @(negedge clk);
        n_chk++;
        if (irq !== 1'b0) $display("FAIL irq_off got %b want 0", irq);
        else n_pass++;
`else
        wb_op(1'b0, 32'hC, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if ({a, e, rd} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL ie_rd_err got ack=%b err=%b dat=%h want 0 1 0", a, e, rd);
        else n_pass++;
        wb_op(1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, rd, a, e);
        n_chk++;
        if ({a, e} !== 2'b01) $display("FAIL ie_wr_err got ack=%b err=%b want 0 1", a, e);
        else n_pass++;
`endif
        wb_op(1'b0, 32'h14, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if ({a, rd} !== {1'b1, 32'h2}) $display("FAIL alias_status got ack=%b dat=%h want 1 00000002", a, rd);
        else n_pass++;
        wb_op(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== {16'h0, cur_div}) $display("FAIL div_kept got %h want %h", rd, cur_div);
        else n_pass++;
    endtask

    task automatic test_ovf_w1c;
        logic [31:0] rd;
        logic a, e;
        set_div(16'd200);
        for (int i = 0; i < DEPTH + 2; i++) begin
            op_we[i] = 1'b1; op_adr[i] = 32'h0;
            op_dat[i] = 32'h0; op_sel[i] = 4'h1;
        end
        op_we[DEPTH+2] = 1'b0; op_adr[DEPTH+2] = 32'h4;
        op_dat[DEPTH+2] = 32'h0; op_sel[DEPTH+2] = 4'hF;
        run_ops(DEPTH + 3);
        n_chk++;
        if (r_dat[DEPTH+2] !== 32'h80D)
            $display("FAIL ovf_set got %h want 0000080d", r_dat[DEPTH+2]);
        else n_pass++;
        wb_op(1'b1, 32'h4, 32'h1, 4'hF, rd, a, e);
        wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== 32'h80D) $display("FAIL w1c_bit0 got %h want 0000080d", rd);
        else n_pass++;
        wb_op(1'b1, 32'h4, 32'h8, 4'hF, rd, a, e);
        wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== 32'h805) $display("FAIL w1c_ovf got %h want 00000805", rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic a, e;
        int s, bad;
        repeat (300) @(negedge clk);
        n_chk++;
        if (txd !== 1'b0) $display("FAIL mid_data_low got %b want 0", txd);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (txd !== 1'b1) $display("FAIL async_txd got %b want 1", txd);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cur_div = DIVR;
        wb_op(1'b0, 32'h4, 32'h0, 4'hF, rd, a, e);
        s = seq_start;
        n_chk++;
        if (rd !== 32'h2) $display("FAIL rst_mid_status got %h want 00000002", rd);
        else n_pass++;
        wb_op(1'b0, 32'h8, 32'h0, 4'hF, rd, a, e);
        n_chk++;
        if (rd !== {16'h0, DIVR}) $display("FAIL rst_mid_div got %h want %h", rd, DIVR);
        else n_pass++;
        repeat (30) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 30; i++) if (wv(s + i) !== 1'b1) bad++;
        n_chk++;
        if (bad != 0) $display("FAIL rst_mid_line got %0d low cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        test_reset;
        test_divisor;
        test_frame;
        test_back_to_back;
        test_unmapped;
        test_ovf_w1c;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
